// File: rtl/cam_match_iterator.sv
// Captures a CAM match vector and streams every set index, one per accepted
// handshake, in a selectable priority order. Zero vectors raise a one-cycle miss.
module cam_match_iterator #(
    parameter int unsigned N         = 32,
    parameter int unsigned IDX_W     = $clog2(N),
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     match_i,
    input  logic             match_valid_i,
    output logic             match_ready_o,
    input  logic             flush_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             idx_valid_o,
    input  logic             idx_ready_i,
    output logic             last_o,
    output logic             miss_o,
    output logic [IDX_W:0]   remaining_o
);

    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_MISS = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] enc_idx;
    logic [CNT_W-1:0] pend_cnt;
    logic [N-1:0]     idx_onehot;

    // Priority encode of the pending register; later loop hits override earlier ones.
    always_comb begin
        enc_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < int'(N); i++) begin
                if (pending_q[i]) enc_idx = IDX_W'(i);
            end
        end else begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (pending_q[i]) enc_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < int'(N); i++) begin
            pend_cnt = pend_cnt + CNT_W'(pending_q[i]);
        end
    end

    assign idx_onehot = {{(N-1){1'b0}}, 1'b1} << enc_idx;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        match_ready_o = 1'b0;
        idx_valid_o   = 1'b0;
        idx_o         = '0;
        last_o        = 1'b0;
        miss_o        = 1'b0;
        remaining_o   = '0;

        case (state_q)
            S_IDLE: begin
                match_ready_o = 1'b1;
                if (match_valid_i) begin
                    pending_d = match_i;
                    state_d   = (|match_i) ? S_ITER : S_MISS;
                end
            end
            S_MISS: begin
                miss_o  = 1'b1;
                state_d = S_IDLE;
            end
            S_ITER: begin
                idx_valid_o = 1'b1;
                idx_o       = enc_idx;
                remaining_o = pend_cnt;
                last_o      = (pend_cnt == CNT_W'(1));
                if (idx_ready_i) begin
                    pending_d = pending_q & ~idx_onehot;
                    if (last_o) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush outranks every handshake, including a vector offered this cycle.
        if (flush_i) begin
            state_d   = S_IDLE;
            pending_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: tb/tb_cam_match_iterator.sv
// Self-checking bench: an MSB-first and an LSB-first instance share stimulus and
// are compared every cycle against a queue-based model plus literal expectations.
module tb_cam_match_iterator;

    localparam int unsigned N     = 32;
    localparam int unsigned IDX_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     match;
    logic             match_valid;
    logic             flush;
    logic             idx_ready;

    logic             rdy_a, vld_a, last_a, miss_a;
    logic [IDX_W-1:0] idx_a;
    logic [IDX_W:0]   rem_a;
    logic             rdy_b, vld_b, last_b, miss_b;
    logic [IDX_W-1:0] idx_b;
    logic [IDX_W:0]   rem_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cam_match_iterator #(.N(N), .IDX_W(IDX_W), .MSB_FIRST(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .match_i(match), .match_valid_i(match_valid),
        .match_ready_o(rdy_a), .flush_i(flush), .idx_o(idx_a), .idx_valid_o(vld_a),
        .idx_ready_i(idx_ready), .last_o(last_a), .miss_o(miss_a), .remaining_o(rem_a)
    );

    cam_match_iterator #(.N(N), .IDX_W(IDX_W), .MSB_FIRST(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .match_i(match), .match_valid_i(match_valid),
        .match_ready_o(rdy_b), .flush_i(flush), .idx_o(idx_b), .idx_valid_o(vld_b),
        .idx_ready_i(idx_ready), .last_o(last_b), .miss_o(miss_b), .remaining_o(rem_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 = waiting for a vector, 1 = streaming, 2 = reporting a miss.
    int mode = 0;
    int qa[$];
    int qb[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode = 0;
            qa.delete();
            qb.delete();
        end else if (flush) begin
            mode = 0;
            qa.delete();
            qb.delete();
        end else begin
            case (mode)
                0: if (match_valid) begin
                    if (match == '0) mode = 2;
                    else begin
                        for (int i = 0; i < int'(N); i++) if (match[i]) qb.push_back(i);
                        for (int i = int'(N) - 1; i >= 0; i--) if (match[i]) qa.push_back(i);
                        mode = 1;
                    end
                end
                2: mode = 0;
                default: if (idx_ready) begin
                    void'(qa.pop_front());
                    void'(qb.pop_front());
                    if (qa.size() == 0) mode = 0;
                end
            endcase
        end
    end

    bit rec = 1'b0;
    int seen_a[$];
    int seen_b[$];

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        chk("ready_a", 32'(rdy_a), 32'(mode == 0));
        chk("ready_b", 32'(rdy_b), 32'(mode == 0));
        chk("miss_a", 32'(miss_a), 32'(mode == 2));
        chk("miss_b", 32'(miss_b), 32'(mode == 2));
        chk("valid_a", 32'(vld_a), 32'(mode == 1));
        chk("valid_b", 32'(vld_b), 32'(mode == 1));
        chk("idx_a", 32'(idx_a), (mode == 1 && qa.size() > 0) ? 32'(qa[0]) : 32'd0);
        chk("idx_b", 32'(idx_b), (mode == 1 && qb.size() > 0) ? 32'(qb[0]) : 32'd0);
        chk("rem_a", 32'(rem_a), (mode == 1) ? 32'(qa.size()) : 32'd0);
        chk("rem_b", 32'(rem_b), (mode == 1) ? 32'(qb.size()) : 32'd0);
        chk("last_a", 32'(last_a), 32'(mode == 1 && qa.size() == 1));
        chk("last_b", 32'(last_b), 32'(mode == 1 && qb.size() == 1));
        if (rec && idx_ready && !flush) begin
            if (vld_a) seen_a.push_back(int'(idx_a));
            if (vld_b) seen_b.push_back(int'(idx_b));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(rdy_a & rdy_b), 32'd1);
        chk({tag, "_valid"}, 32'(vld_a | vld_b), 32'd0);
        chk({tag, "_miss"}, 32'(miss_a | miss_b), 32'd0);
        chk({tag, "_last"}, 32'(last_a | last_b), 32'd0);
        chk({tag, "_idx"}, 32'(idx_a | idx_b), 32'd0);
        chk({tag, "_rem"}, 32'(rem_a | rem_b), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; match = '0; match_valid = 1'b0; flush = 1'b0; idx_ready = 1'b0;
        repeat (2) @(posedge clk);
        mid();
        chk_reset_vals("reset");
        step();
        rst_n = 1'b1;
        step();

        // Three-match vector, both priority orders, consumer always ready.
        match = 32'h8000_0011; match_valid = 1'b1; idx_ready = 1'b1;
        step();
        match_valid = 1'b0;
        mid();
        chk("t1_idx_a0", 32'(idx_a), 32'd31); chk("t1_idx_b0", 32'(idx_b), 32'd0);
        chk("t1_rem0", 32'(rem_a), 32'd3);    chk("t1_last0", 32'(last_a), 32'd0);
        step(); mid();
        chk("t1_idx_a1", 32'(idx_a), 32'd4);  chk("t1_idx_b1", 32'(idx_b), 32'd4);
        chk("t1_rem1", 32'(rem_a), 32'd2);
        step(); mid();
        chk("t1_idx_a2", 32'(idx_a), 32'd0);  chk("t1_idx_b2", 32'(idx_b), 32'd31);
        chk("t1_last2", 32'(last_a & last_b), 32'd1); chk("t1_rem2", 32'(rem_b), 32'd1);
        step(); mid();
        chk("t1_done_ready", 32'(rdy_a), 32'd1); chk("t1_done_valid", 32'(vld_a), 32'd0);

        // Zero vector: single miss pulse, then ready again.
        match = '0; match_valid = 1'b1;
        step();
        match_valid = 1'b0;
        mid();
        chk("t2_miss", 32'(miss_a & miss_b), 32'd1);
        chk("t2_ready", 32'(rdy_a), 32'd0); chk("t2_valid", 32'(vld_a), 32'd0);
        step(); mid();
        chk("t2_miss_end", 32'(miss_a), 32'd0); chk("t2_ready_back", 32'(rdy_a), 32'd1);

        // All-ones vector with a stalling consumer.
        match = 32'hFFFF_FFFF; match_valid = 1'b1; idx_ready = 1'b0;
        step();
        match_valid = 1'b0;
        mid();
        chk("t3_rem32", 32'(rem_a), 32'd32); chk("t3_first", 32'(idx_a), 32'd31);
        rec = 1'b1;
        begin
            int cyc;
            cyc = 0;
            while (vld_a && cyc < 200) begin
                @(posedge clk); #1;
                idx_ready = cyc[0];
                cyc++;
                @(negedge clk); #1;
            end
            chk("t3_timeout", 32'(cyc < 200), 32'd1);
        end
        rec = 1'b0;
        idx_ready = 1'b1;
        chk("t3_count_a", 32'(seen_a.size()), 32'd32);
        chk("t3_count_b", 32'(seen_b.size()), 32'd32);
        if (seen_a.size() == 32 && seen_b.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                chk("t3_order_a", 32'(seen_a[i]), 32'(31 - i));
                chk("t3_order_b", 32'(seen_b[i]), 32'(i));
            end
        end
        step();

        // Flush after the first handshake; remaining indices never accepted.
        match = 32'h0000_00F0; match_valid = 1'b1; idx_ready = 1'b1;
        step();
        match_valid = 1'b0;
        mid();
        chk("t4_idx_a", 32'(idx_a), 32'd7); chk("t4_idx_b", 32'(idx_b), 32'd4);
        step();
        idx_ready = 1'b0; flush = 1'b1;
        mid();
        chk("t4_next_a", 32'(idx_a), 32'd6);
        step();
        flush = 1'b0;
        mid();
        chk("t4_idle_ready", 32'(rdy_a), 32'd1); chk("t4_idle_valid", 32'(vld_a | vld_b), 32'd0);
        chk("t4_no_miss", 32'(miss_a | miss_b), 32'd0);

        // Flush beats a vector offered in the same idle cycle.
        match = 32'h1; match_valid = 1'b1; flush = 1'b1;
        step();
        match_valid = 1'b0; flush = 1'b0;
        mid();
        chk("t5_not_captured", 32'(vld_a | miss_a), 32'd0); chk("t5_ready", 32'(rdy_a), 32'd1);

        // Asynchronous reset in the middle of an iteration.
        match = 32'hFFFF_FFFF; match_valid = 1'b1; idx_ready = 1'b0;
        step();
        match_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        step();
        rst_n = 1'b1;
        step();

        // Single match; a vector offered with the final handshake is dropped.
        match = 32'h2; match_valid = 1'b1; idx_ready = 1'b1;
        step();
        match = 32'h4;
        mid();
        chk("t6_idx", 32'(idx_a), 32'd1); chk("t6_last", 32'(last_a & last_b), 32'd1);
        chk("t6_idx_b", 32'(idx_b), 32'd1);
        step();
        match_valid = 1'b0;
        mid();
        chk("t6_dropped", 32'(vld_a | miss_a), 32'd0); chk("t6_ready", 32'(rdy_a), 32'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
